// File: rtl/lsu_mmio_multi.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mmio_multi
// Purpose  : Load/store unit between the MEM stage and a word-addressed data
//            RAM plus an MMIO window of NUM_UART UART register banks.
//            RV32 B/H/W/BU/HU accesses, get/busy handshake, registered load
//            response (1 cycle after accept), TX back-pressure.
// Ports    : clk, rst (async, active high)
//            get/opcode/funct3/address/data_in  -> request
//            busy, data_out, load_valid, err    -> handshake / response
//            uart_tx_* / uart_rx_* / uart_baud   -> per-channel UART signals
// Config   : MISALIGN_TRAP_EN defined  -> misaligned H/W rejected, err pulses
//            MISALIGN_TRAP_EN undefined -> offending low bits forced to 0
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mmio_multi #(
    parameter int                DEPTH      = 256,
    parameter int                NUM_UART   = 2,
    parameter logic [31:0]       MMIO_BASE  = 32'h400,
    parameter int                BAUD_W     = 16,
    parameter logic [BAUD_W-1:0] BAUD_RESET = 16'd10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       get,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic [31:0]                address,
    input  logic [31:0]                data_in,
    output logic                       busy,
    output logic [31:0]                data_out,
    output logic                       load_valid,
    output logic                       err,
    output logic [8*NUM_UART-1:0]      uart_tx_data,
    output logic [NUM_UART-1:0]        uart_tx_start,
    input  logic [NUM_UART-1:0]        uart_tx_busy,
    input  logic [8*NUM_UART-1:0]      uart_rx_data,
    input  logic [NUM_UART-1:0]        uart_rx_valid,
    output logic [NUM_UART-1:0]        uart_rx_ack,
    output logic [BAUD_W*NUM_UART-1:0] uart_baud
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          CW         = (NUM_UART > 1) ? $clog2(NUM_UART) : 1;
    localparam logic [31:0] c_RAM_END  = 32'(DEPTH * 4);
    localparam logic [31:0] c_MMIO_END = MMIO_BASE + 32'(16 * NUM_UART);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_RESP    = 2'd1;
    localparam logic [1:0]  c_TX_WAIT = 2'd2;

    logic [1:0]        r_state, w_next;
    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_ram_q;
    logic [31:0]       r_rdata;
    logic              r_is_ram;
    logic [1:0]        r_lane;
    logic [2:0]        r_f3;
    logic              r_rx_pop;
    logic [CW-1:0]     r_ch;
    logic [7:0]        r_tx_data [NUM_UART];
    logic [NUM_UART-1:0] r_tx_start;
    logic [BAUD_W-1:0] r_baud [NUM_UART];

    // ---------------- request decode ----------------
    logic              w_accept, w_is_load, w_is_store, w_in_ram, w_in_mmio;
    logic [31:0]       w_off;
    logic [CW-1:0]     w_ch;
    logic [1:0]        w_reg;
    logic              w_size_h, w_size_w, w_reject, w_tx_wr;
    logic [1:0]        w_lane;
    logic [AW-1:0]     w_idx;

    assign w_accept   = get && (r_state == c_IDLE);
    assign w_is_load  = (opcode == 7'b0000011);
    assign w_is_store = (opcode == 7'b0100011);
    assign w_in_ram   = (address < c_RAM_END);
    assign w_in_mmio  = (address >= MMIO_BASE) && (address < c_MMIO_END);
    assign w_off      = address - MMIO_BASE;
    assign w_ch       = w_off[CW+3:4];
    assign w_reg      = w_off[3:2];
    assign w_idx      = address[AW+1:2];
    assign w_size_h   = (funct3[1:0] == 2'b01);
    assign w_size_w   = funct3[1];

    logic w_unused_bits;
    assign w_unused_bits = ^{w_off[31:CW+4], w_off[1:0]};

`ifdef MISALIGN_TRAP_EN
    logic r_err;
    assign w_reject = (w_size_h && address[0]) || (w_size_w && (address[1:0] != 2'b00));
    assign w_lane   = address[1:0];
    assign err      = r_err;
`else
    assign w_reject = 1'b0;
    // Misaligned accesses are silently aligned down to their natural boundary.
    assign w_lane   = w_size_w ? 2'b00 : (w_size_h ? {address[1], 1'b0} : address[1:0]);
    assign err      = 1'b0;
`endif

    assign w_tx_wr = w_in_mmio && (w_reg == 2'd0) && !w_reject;

    // ---------------- store lane steering ----------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_ram_we;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = data_in;
        if (funct3[1:0] == 2'b00) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{data_in[7:0]}};
        end else if (w_size_h) begin
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{data_in[15:0]}};
        end
    end

    assign w_ram_we = w_accept && w_is_store && w_in_ram && !w_reject;

    // RAM has no reset; r_ram_q is consumed only in the RESP cycle after a load accept.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
        r_ram_q <= r_mem[w_idx];
    end

    // ---------------- MMIO read mux ----------------
    logic [31:0] w_mmio_rd;
    always_comb begin
        w_mmio_rd = 32'd0;
        case (w_reg)
            2'd1:    w_mmio_rd = uart_rx_valid[w_ch] ? {24'd0, uart_rx_data[8*w_ch +: 8]} : 32'd0;
            2'd2:    w_mmio_rd = {26'd0, uart_rx_valid[w_ch], 4'd0, uart_tx_busy[w_ch]};
            2'd3:    w_mmio_rd = 32'(r_baud[w_ch]);
            default: w_mmio_rd = 32'd0;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && w_is_load)
                    w_next = c_RESP;
                else if (w_accept && w_is_store && w_tx_wr && uart_tx_busy[w_ch])
                    w_next = c_TX_WAIT;
            end
            c_RESP:    w_next = c_IDLE;
            c_TX_WAIT: if (!uart_tx_busy[r_ch]) w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic [31:0] w_word, w_shift;
    assign w_word  = r_is_ram ? r_ram_q : r_rdata;
    assign w_shift = w_word >> {r_lane, 3'b000};

    always_comb begin
        busy        = (r_state != c_IDLE);
        load_valid  = (r_state == c_RESP);
        data_out    = 32'd0;
        uart_rx_ack = '0;
        if (r_state == c_RESP) begin
            case (r_f3[1:0])
                2'b00:   data_out = {{24{~r_f3[2] & w_shift[7]}},  w_shift[7:0]};
                2'b01:   data_out = {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]};
                default: data_out = w_word;
            endcase
            if (r_rx_pop) uart_rx_ack[r_ch] = 1'b1;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= 32'd0;
            r_is_ram   <= 1'b0;
            r_lane     <= 2'd0;
            r_f3       <= 3'd0;
            r_rx_pop   <= 1'b0;
            r_ch       <= '0;
            r_tx_start <= '0;
            for (int c = 0; c < NUM_UART; c++) begin
                r_tx_data[c] <= 8'd0;
                r_baud[c]    <= BAUD_RESET;
            end
`ifdef MISALIGN_TRAP_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_tx_start <= '0;
`ifdef MISALIGN_TRAP_EN
            r_err      <= w_accept && (w_is_load || w_is_store) && w_reject;
`endif
            if (w_accept && w_is_load) begin
                r_is_ram <= w_in_ram && !w_reject;
                r_rdata  <= (w_in_mmio && !w_reject) ? w_mmio_rd : 32'd0;
                r_lane   <= (w_in_mmio || w_reject) ? 2'd0 : w_lane;
                r_f3     <= (w_in_mmio || w_reject) ? 3'b010 : funct3;
                r_rx_pop <= w_in_mmio && !w_reject && (w_reg == 2'd1) && uart_rx_valid[w_ch];
                r_ch     <= w_ch;
            end
            if (w_accept && w_is_store && w_in_mmio && !w_reject) begin
                if (w_reg == 2'd0) begin
                    r_tx_data[w_ch] <= data_in[7:0];
                    r_ch            <= w_ch;
                    if (!uart_tx_busy[w_ch]) r_tx_start[w_ch] <= 1'b1;
                end
                if (w_reg == 2'd3) r_baud[w_ch] <= data_in[BAUD_W-1:0];
            end
            if (r_state == c_TX_WAIT && !uart_tx_busy[r_ch]) r_tx_start[r_ch] <= 1'b1;
        end
    end

    // ---------------- flatten per-channel outputs ----------------
    assign uart_tx_start = r_tx_start;
    generate
        for (genvar c = 0; c < NUM_UART; c++) begin : g_ch
            assign uart_tx_data[8*c +: 8]         = r_tx_data[c];
            assign uart_baud[BAUD_W*c +: BAUD_W]  = r_baud[c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lsu_mmio_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mmio_multi
// Purpose  : Directed self-checking bench for lsu_mmio_multi (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mmio_multi;

    localparam logic [6:0] c_LOAD  = 7'b0000011;
    localparam logic [6:0] c_STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        get;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        busy;
    logic [31:0] data_out;
    logic        load_valid;
    logic        err;
    logic [15:0] uart_tx_data;
    logic [1:0]  uart_tx_start;
    logic [1:0]  uart_tx_busy;
    logic [15:0] uart_rx_data;
    logic [1:0]  uart_rx_valid;
    logic [1:0]  uart_rx_ack;
    logic [31:0] uart_baud;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mmio_multi dut (
        .clk           (clk),
        .rst           (rst),
        .get           (get),
        .opcode        (opcode),
        .funct3        (funct3),
        .address       (address),
        .data_in       (data_in),
        .busy          (busy),
        .data_out      (data_out),
        .load_valid    (load_valid),
        .err           (err),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ack   (uart_rx_ack),
        .uart_baud     (uart_baud)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge, hold it until accepted; return #1 after the accept edge.
    task automatic do_req(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        get = 1'b1; opcode = op; funct3 = f3; address = a; data_in = d;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_accept_wait", busy, 1'b0);
        @(posedge clk);
        #1 get = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp, output logic [1:0] ack, output logic e);
        do_req(c_LOAD, f3, a, 32'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, load_valid, 1'b1);
        check_eq({tag, "_data"},  data_out, exp);
        ack = uart_rx_ack;
        e   = err;
    endtask

    logic [1:0] ack;
    logic       e;
    int         busy_cnt, starts;

    initial begin
        rst = 1'b1; get = 1'b0; opcode = 7'd0; funct3 = 3'd0; address = 32'd0; data_in = 32'd0;
        uart_tx_busy = 2'b00; uart_rx_data = 16'd0; uart_rx_valid = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",     busy, 1'b0);
        check_eq("rst_valid",    load_valid, 1'b0);
        check_eq("rst_data",     data_out, 32'd0);
        check_eq("rst_err",      err, 1'b0);
        check_eq("rst_txstart",  uart_tx_start, 2'b00);
        check_eq("rst_rxack",    uart_rx_ack, 2'b00);
        check_eq("rst_txdata",   uart_tx_data, 16'd0);
        check_eq("rst_baud",     uart_baud, {16'd10, 16'd10});
        rst = 1'b0;

        // 1) word store / load
        do_req(c_STORE, 3'b010, 32'd20, 32'h1234abcd);
        check_eq("sw_busy", busy, 1'b0);
        do_load("lw20", 3'b010, 32'd20, 32'h1234abcd, ack, e);
        @(negedge clk);
        check_eq("lw_pulse_end", load_valid, 1'b0);

        // 2) byte store, sign/zero extension
        do_req(c_STORE, 3'b000, 32'd21, 32'h00000080);
        do_load("lb21",  3'b000, 32'd21, 32'hffffff80, ack, e);
        do_load("lbu21", 3'b100, 32'd21, 32'h00000080, ack, e);
        do_load("lh20",  3'b001, 32'd20, 32'hffff80cd, ack, e);
        do_load("lhu22", 3'b101, 32'd22, 32'h00001234, ack, e);
        do_load("unmapped", 3'b010, 32'h800, 32'd0, ack, e);

        // 3) baud registers
        do_load("baud1_rst", 3'b010, 32'h41C, 32'd10, ack, e);
        do_req(c_STORE, 3'b010, 32'h40C, 32'd10);
        do_req(c_STORE, 3'b010, 32'h41C, 32'h0000_0123);
        @(negedge clk);
        check_eq("baud_wr", uart_baud, {16'h0123, 16'd10});
        do_load("baud0_rd", 3'b010, 32'h40C, 32'd10, ack, e);

        // 4) TX back-pressure on channel 0
        uart_tx_busy = 2'b01;
        do_req(c_STORE, 3'b010, 32'h400, 32'h0000000f);
        busy_cnt = 0; starts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            starts   += int'(uart_tx_start[0]);
            if (i == 0) begin
                get = 1'b1; opcode = c_STORE; funct3 = 3'b010; address = 32'h40C; data_in = 32'h55;
            end
            if (i == 1) get = 1'b0;
            if (i == 2) uart_tx_busy = 2'b00;
        end
        check_eq("tx_busy_cycles", busy_cnt, 3);
        check_eq("tx_start_count", starts, 1);
        check_eq("tx_data0", uart_tx_data[7:0], 8'h0f);
        check_eq("get_ignored", uart_baud, {16'h0123, 16'd10});

        // TX store with idle transmitter: pulse next cycle, no busy
        do_req(c_STORE, 3'b010, 32'h410, 32'h000000a5);
        check_eq("tx1_nobusy", busy, 1'b0);
        check_eq("tx1_start",  uart_tx_start, 2'b10);
        check_eq("tx1_data",   uart_tx_data[15:8], 8'ha5);

        // 5) RX channel 1
        uart_rx_valid = 2'b10; uart_rx_data = 16'h3400;
        do_load("status1", 3'b010, 32'h418, 32'h20, ack, e);
        check_eq("status_noack", ack, 2'b00);
        do_load("rx1", 3'b010, 32'h414, 32'h34, ack, e);
        check_eq("rx1_ack", ack, 2'b10);
        @(negedge clk);
        check_eq("rx1_ack_end", uart_rx_ack, 2'b00);
        uart_rx_valid = 2'b00;
        do_load("rx1_empty", 3'b010, 32'h414, 32'd0, ack, e);
        check_eq("rx1_empty_ack", ack, 2'b00);

        // 6) misaligned word load
`ifdef MISALIGN_TRAP_EN
        do_load("lw22", 3'b010, 32'd22, 32'd0, ack, e);
        check_eq("lw22_err", e, 1'b1);
`else
        do_load("lw22", 3'b010, 32'd22, 32'h123480cd, ack, e);
        check_eq("lw22_err", e, 1'b0);
`endif

        // reset while waiting on a busy transmitter
        uart_tx_busy = 2'b10;
        do_req(c_STORE, 3'b010, 32'h410, 32'h77);
        @(negedge clk);
        check_eq("txw_busy", busy, 1'b1);
        rst = 1'b1;
        #2;
        check_eq("txw_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0; uart_tx_busy = 2'b00;
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            starts += int'(|uart_tx_start);
        end
        check_eq("txw_dropped", starts, 0);
        check_eq("txw_txdata_rst", uart_tx_data, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
